// File: rtl/ysyx_22050133_axi_arbiter.sv
// Two-master (icache / dcache) burst arbiter in front of a single AXI-like port.
// One burst owns the downstream port from address handshake to its last beat.
// After the last beat, one idle cycle re-arbitrates with round-robin on conflict.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   {i,d}_rw_addr_*          upstream burst request (valid/ready + addr, we, len, size, burst, if)
//   {i,d}_w_data_*           upstream write beats (valid/ready/data)
//   {i,d}_r_data_*           upstream read beats (valid/ready/data)
//   axi_rw_addr_*            downstream burst request
//   axi_w_data_*, axi_r_data_*  downstream beat channels
module ysyx_22050133_axi_arbiter #(
    parameter int unsigned RW_DATA_WIDTH = 64,
    parameter int unsigned RW_ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     i_rw_addr_valid_i,
    output logic                     i_rw_addr_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] i_rw_addr_i,
    input  logic                     i_rw_we_i,
    input  logic [7:0]               i_rw_len_i,
    input  logic [2:0]               i_rw_size_i,
    input  logic [1:0]               i_rw_burst_i,
    input  logic                     i_rw_if_i,
    input  logic                     i_w_data_valid_i,
    output logic                     i_w_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] i_w_data_i,
    output logic                     i_r_data_valid_o,
    input  logic                     i_r_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] i_r_data_o,

    input  logic                     d_rw_addr_valid_i,
    output logic                     d_rw_addr_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] d_rw_addr_i,
    input  logic                     d_rw_we_i,
    input  logic [7:0]               d_rw_len_i,
    input  logic [2:0]               d_rw_size_i,
    input  logic [1:0]               d_rw_burst_i,
    input  logic                     d_rw_if_i,
    input  logic                     d_w_data_valid_i,
    output logic                     d_w_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] d_w_data_i,
    output logic                     d_r_data_valid_o,
    input  logic                     d_r_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] d_r_data_o,

    output logic                     axi_rw_addr_valid_o,
    input  logic                     axi_rw_addr_ready_i,
    output logic [RW_ADDR_WIDTH-1:0] axi_rw_addr_o,
    output logic                     axi_rw_we_o,
    output logic [7:0]               axi_rw_len_o,
    output logic [2:0]               axi_rw_size_o,
    output logic [1:0]               axi_rw_burst_o,
    output logic                     axi_rw_if_o,
    output logic                     axi_w_data_valid_o,
    input  logic                     axi_w_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] axi_w_data_o,
    input  logic                     axi_r_data_valid_i,
    output logic                     axi_r_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] axi_r_data_i
);

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t             state, state_n;
    logic               grant, grant_n;   // 0 = icache, 1 = dcache
    logic               last, last_n;     // owner of the most recent completed burst
    logic               we_q, we_n;
    logic [LEN_W-1:0]   cnt, cnt_n;       // beats remaining after the current one

    // Request and beat fields of whichever master currently holds the grant
    logic                     g_addr_valid;
    logic [RW_ADDR_WIDTH-1:0] g_addr;
    logic                     g_we;
    logic [LEN_W-1:0]         g_len;
    logic [SIZE_W-1:0]        g_size;
    logic [BURST_W-1:0]       g_burst;
    logic                     g_if;
    logic                     g_w_valid;
    logic [RW_DATA_WIDTH-1:0] g_w_data;
    logic                     g_r_ready;
    logic                     beat_hs;

    // Granted-master field select
    always_comb begin
        if (grant) begin
            g_addr_valid = d_rw_addr_valid_i;
            g_addr       = d_rw_addr_i;
            g_we         = d_rw_we_i;
            g_len        = d_rw_len_i;
            g_size       = d_rw_size_i;
            g_burst      = d_rw_burst_i;
            g_if         = d_rw_if_i;
            g_w_valid    = d_w_data_valid_i;
            g_w_data     = d_w_data_i;
            g_r_ready    = d_r_data_ready_i;
        end else begin
            g_addr_valid = i_rw_addr_valid_i;
            g_addr       = i_rw_addr_i;
            g_we         = i_rw_we_i;
            g_len        = i_rw_len_i;
            g_size       = i_rw_size_i;
            g_burst      = i_rw_burst_i;
            g_if         = i_rw_if_i;
            g_w_valid    = i_w_data_valid_i;
            g_w_data     = i_w_data_i;
            g_r_ready    = i_r_data_ready_i;
        end
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            grant <= 1'b0;
            last  <= 1'b0;
            we_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
            we_q  <= we_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and passthrough outputs; everything idles at zero
    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        we_n    = we_q;
        cnt_n   = cnt;
        beat_hs = 1'b0;

        i_rw_addr_ready_o   = 1'b0;
        i_w_data_ready_o    = 1'b0;
        i_r_data_valid_o    = 1'b0;
        i_r_data_o          = '0;
        d_rw_addr_ready_o   = 1'b0;
        d_w_data_ready_o    = 1'b0;
        d_r_data_valid_o    = 1'b0;
        d_r_data_o          = '0;
        axi_rw_addr_valid_o = 1'b0;
        axi_rw_addr_o       = '0;
        axi_rw_we_o         = 1'b0;
        axi_rw_len_o        = '0;
        axi_rw_size_o       = '0;
        axi_rw_burst_o      = '0;
        axi_rw_if_o         = 1'b0;
        axi_w_data_valid_o  = 1'b0;
        axi_w_data_o        = '0;
        axi_r_data_ready_o  = 1'b0;

        case (state)
            S_IDLE: begin
                // On conflict, the master that did not finish last wins
                if (i_rw_addr_valid_i && d_rw_addr_valid_i) begin
                    grant_n = ~last;
                    state_n = S_ADDR;
                end else if (i_rw_addr_valid_i) begin
                    grant_n = 1'b0;
                    state_n = S_ADDR;
                end else if (d_rw_addr_valid_i) begin
                    grant_n = 1'b1;
                    state_n = S_ADDR;
                end
            end

            S_ADDR: begin
                axi_rw_addr_valid_o = g_addr_valid;
                axi_rw_addr_o       = g_addr;
                axi_rw_we_o         = g_we;
                axi_rw_len_o        = g_len;
                axi_rw_size_o       = g_size;
                axi_rw_burst_o      = g_burst;
                axi_rw_if_o         = g_if;
                if (grant) begin
                    d_rw_addr_ready_o = axi_rw_addr_ready_i;
                end else begin
                    i_rw_addr_ready_o = axi_rw_addr_ready_i;
                end
                if (g_addr_valid && axi_rw_addr_ready_i) begin
                    we_n    = g_we;
                    cnt_n   = g_len;
                    state_n = S_DATA;
                end
            end

            S_DATA: begin
                if (we_q) begin
                    axi_w_data_valid_o = g_w_valid;
                    axi_w_data_o       = g_w_data;
                    if (grant) begin
                        d_w_data_ready_o = axi_w_data_ready_i;
                    end else begin
                        i_w_data_ready_o = axi_w_data_ready_i;
                    end
                    beat_hs = g_w_valid && axi_w_data_ready_i;
                end else begin
                    axi_r_data_ready_o = g_r_ready;
                    if (grant) begin
                        d_r_data_valid_o = axi_r_data_valid_i;
                        d_r_data_o       = axi_r_data_i;
                    end else begin
                        i_r_data_valid_o = axi_r_data_valid_i;
                        i_r_data_o       = axi_r_data_i;
                    end
                    beat_hs = axi_r_data_valid_i && g_r_ready;
                end
                if (beat_hs) begin
                    if (cnt == '0) begin
                        state_n = S_IDLE;
                        last_n  = grant;
                    end else begin
                        cnt_n = cnt - LEN_W'(1);
                    end
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050133_axi_arbiter.sv
// Randomized bench for the icache/dcache arbiter: two master agents, a memory slave
// and a transaction-level reference of ownership, round-robin and beat passthrough.
module tb_ysyx_22050133_axi_arbiter;

    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 32;
    localparam int unsigned NCYC = 10000;
    localparam logic [AW-1:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // master-side stimulus (index 0 = icache, 1 = dcache)
    logic          m_valid  [2];
    logic [AW-1:0] m_addr   [2];
    logic          m_we     [2];
    logic [7:0]    m_len    [2];
    logic [2:0]    m_size   [2];
    logic [1:0]    m_burst  [2];
    logic          m_wvalid [2];
    logic [DW-1:0] m_wdata  [2];
    logic          m_rready [2];
    // slave-side stimulus
    logic          s_aready, s_wready, s_rvalid;
    logic [DW-1:0] s_rdata;
    // DUT outputs
    logic          i_aready, i_wready, i_rvalid, d_aready, d_wready, d_rvalid;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          a_valid, a_we, a_if, a_wvalid, a_rready;
    logic [AW-1:0] a_addr;
    logic [7:0]    a_len;
    logic [2:0]    a_size;
    logic [1:0]    a_burst;
    logic [DW-1:0] a_wdata;

    ysyx_22050133_axi_arbiter #(.RW_DATA_WIDTH(DW), .RW_ADDR_WIDTH(AW)) dut (
        .clk                 (clk),
        .rst                 (rst_n),
        .i_rw_addr_valid_i   (m_valid[0]),
        .i_rw_addr_ready_o   (i_aready),
        .i_rw_addr_i         (m_addr[0]),
        .i_rw_we_i           (m_we[0]),
        .i_rw_len_i          (m_len[0]),
        .i_rw_size_i         (m_size[0]),
        .i_rw_burst_i        (m_burst[0]),
        .i_rw_if_i           (1'b1),
        .i_w_data_valid_i    (m_wvalid[0]),
        .i_w_data_ready_o    (i_wready),
        .i_w_data_i          (m_wdata[0]),
        .i_r_data_valid_o    (i_rvalid),
        .i_r_data_ready_i    (m_rready[0]),
        .i_r_data_o          (i_rdata),
        .d_rw_addr_valid_i   (m_valid[1]),
        .d_rw_addr_ready_o   (d_aready),
        .d_rw_addr_i         (m_addr[1]),
        .d_rw_we_i           (m_we[1]),
        .d_rw_len_i          (m_len[1]),
        .d_rw_size_i         (m_size[1]),
        .d_rw_burst_i        (m_burst[1]),
        .d_rw_if_i           (1'b0),
        .d_w_data_valid_i    (m_wvalid[1]),
        .d_w_data_ready_o    (d_wready),
        .d_w_data_i          (m_wdata[1]),
        .d_r_data_valid_o    (d_rvalid),
        .d_r_data_ready_i    (m_rready[1]),
        .d_r_data_o          (d_rdata),
        .axi_rw_addr_valid_o (a_valid),
        .axi_rw_addr_ready_i (s_aready),
        .axi_rw_addr_o       (a_addr),
        .axi_rw_we_o         (a_we),
        .axi_rw_len_o        (a_len),
        .axi_rw_size_o       (a_size),
        .axi_rw_burst_o      (a_burst),
        .axi_rw_if_o         (a_if),
        .axi_w_data_valid_o  (a_wvalid),
        .axi_w_data_ready_i  (s_wready),
        .axi_w_data_o        (a_wdata),
        .axi_r_data_valid_i  (s_rvalid),
        .axi_r_data_ready_o  (a_rready),
        .axi_r_data_i        (s_rdata)
    );

    int checks = 0;
    int errors = 0;

    // memory contents as seen downstream, and as intended by the masters
    logic [DW-1:0] mem    [256];
    logic [DW-1:0] shadow [256];

    // master agents: 0 idle, 1 requesting, 2 in burst
    int mst [2];
    int beat[2];
    int mbase[2];
    int wt  [2];
    int fgn [2];
    // slave agent
    bit s_act, s_we;
    int s_base, s_len, s_beat;
    // reference: current owner (-1 none), address phase flag, beats left, last owner
    int own, left;
    bit aph, mwe, lst;
    bit prev_av, did_rst;
    int ngrant;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [66:0] pk_m(input logic ar, input logic wr, input logic rv,
                                         input logic [DW-1:0] rd);
        return {ar, wr, rv, rd};
    endfunction

    function automatic logic [113:0] pk_a(input logic v, input logic [AW-1:0] ad, input logic we,
                                          input logic [7:0] len, input logic [2:0] sz,
                                          input logic [1:0] bu, input logic fi, input logic wv,
                                          input logic [DW-1:0] wd, input logic rr);
        return {v, ad, we, len, sz, bu, fi, wv, wd, rr};
    endfunction

    task automatic clear_agents();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0; m_addr[m] = '0; m_we[m] = 1'b0; m_len[m] = '0;
            m_size[m] = '0; m_burst[m] = '0; m_wvalid[m] = 1'b0; m_wdata[m] = '0;
            m_rready[m] = 1'b0; mst[m] = 0; beat[m] = 0; wt[m] = 0; fgn[m] = 0; mbase[m] = 0;
        end
        s_aready = 1'b0; s_wready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        s_act = 1'b0; s_we = 1'b0; s_base = 0; s_len = 0; s_beat = 0;
        own = -1; aph = 1'b0; left = 0; mwe = 1'b0; lst = 1'b0; prev_av = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_i"}, 128'(pk_m(i_aready, i_wready, i_rvalid, i_rdata)), '0);
        chk({tag, "_d"}, 128'(pk_m(d_aready, d_wready, d_rvalid, d_rdata)), '0);
        chk({tag, "_axi"}, 128'(pk_a(a_valid, a_addr, a_we, a_len, a_size, a_burst, a_if,
                                     a_wvalid, a_wdata, a_rready)), '0);
    endtask

    task automatic drive(input int cyc);
        int lsel;
        for (int m = 0; m < 2; m++) begin
            if (mst[m] == 0) begin
                m_valid[m] = 1'b0;
                if (cyc == 0 || $urandom_range(99) < 30) begin
                    lsel       = int'($urandom_range(3));
                    m_len[m]   = (lsel == 0) ? 8'd0 : (lsel == 1) ? 8'd1 : (lsel == 2) ? 8'd3 : 8'd7;
                    m_we[m]    = (m == 1) ? 1'($urandom_range(1)) : 1'b0;
                    mbase[m]   = int'($urandom_range(31)) * 8;
                    if (cyc == 0) begin
                        m_len[m] = 8'd7;
                        m_we[m]  = (m == 1);
                        mbase[m] = 0;
                    end
                    m_addr[m]  = BASE + AW'(mbase[m] * 8);
                    m_size[m]  = 3'($urandom_range(7));
                    m_burst[m] = 2'($urandom_range(3));
                    m_valid[m] = 1'b1;
                    mst[m] = 1;
                    wt[m]  = 0;
                end
            end
            if (mst[m] == 2) begin
                m_valid[m] = 1'b0;
                if (m_we[m]) begin
                    m_wvalid[m] = ($urandom_range(99) < 70);
                    m_rready[m] = 1'($urandom_range(1));
                end else begin
                    m_rready[m] = ($urandom_range(99) < 70);
                    m_wvalid[m] = 1'($urandom_range(1));
                end
            end else begin
                m_wvalid[m] = 1'($urandom_range(1));
                m_rready[m] = 1'($urandom_range(1));
            end
            m_wdata[m] = {$urandom, $urandom};
        end
        s_aready = ($urandom_range(99) < 60);
        s_wready = 1'($urandom_range(1));
        s_rvalid = ($urandom_range(99) < 50);
        s_rdata  = {$urandom, $urandom};
        if (s_act && !s_we) s_rdata = mem[(s_base + s_beat) & 255];
    endtask

    task automatic check_cycle();
        logic [66:0]  em [2];
        logic [113:0] ea;
        em[0] = '0; em[1] = '0; ea = '0;
        if (own >= 0) begin
            if (aph) begin
                ea = pk_a(m_valid[own], m_addr[own], m_we[own], m_len[own], m_size[own],
                          m_burst[own], own == 0, 1'b0, '0, 1'b0);
                em[own] = pk_m(s_aready, 1'b0, 1'b0, '0);
            end else if (mwe) begin
                ea = pk_a(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, m_wvalid[own], m_wdata[own], 1'b0);
                em[own] = pk_m(1'b0, s_wready, 1'b0, '0);
            end else begin
                ea = pk_a(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, m_rready[own]);
                em[own] = pk_m(1'b0, 1'b0, s_rvalid, s_rdata);
            end
        end
        chk("i_port", 128'(pk_m(i_aready, i_wready, i_rvalid, i_rdata)), 128'(em[0]));
        chk("d_port", 128'(pk_m(d_aready, d_wready, d_rvalid, d_rdata)), 128'(em[1]));
        chk("axi_port", 128'(pk_a(a_valid, a_addr, a_we, a_len, a_size, a_burst, a_if,
                                  a_wvalid, a_wdata, a_rready)), 128'(ea));
    endtask

    task automatic update();
        logic          oa [2];
        logic          ow [2];
        logic          orv[2];
        logic [DW-1:0] ord[2];
        logic [AW-1:0] off;
        int ob;
        bit hs;
        oa[0] = i_aready; ow[0] = i_wready; orv[0] = i_rvalid; ord[0] = i_rdata;
        oa[1] = d_aready; ow[1] = d_wready; orv[1] = d_rvalid; ord[1] = d_rdata;

        // fairness: a waiting master sees at most one foreign grant
        if (a_valid && !prev_av) begin
            ob = a_if ? 0 : 1;
            if (ngrant == 0) chk("first_grant", 128'(ob), 128'(1));
            if (ngrant == 1) chk("second_grant", 128'(ob), 128'(0));
            ngrant++;
            fgn[ob] = 0;
            if (m_valid[1 - ob]) begin
                fgn[1 - ob]++;
                chk(ob == 1 ? "fair_i" : "fair_d", 128'(fgn[1 - ob] > 1), 128'(0));
            end
        end
        prev_av = a_valid;

        // master agents observe their own handshakes
        for (int m = 0; m < 2; m++) begin
            if (mst[m] == 1 && oa[m]) begin
                mst[m]  = 2;
                beat[m] = 0;
            end else if (mst[m] == 2) begin
                if (m_we[m] && m_wvalid[m] && ow[m]) begin
                    shadow[(mbase[m] + beat[m]) & 255] = m_wdata[m];
                    beat[m]++;
                end else if (!m_we[m] && orv[m] && m_rready[m]) begin
                    chk(m == 0 ? "rdata_i" : "rdata_d", 128'(ord[m]),
                        128'(shadow[(mbase[m] + beat[m]) & 255]));
                    beat[m]++;
                end
                if (beat[m] > int'(m_len[m])) mst[m] = 0;
            end
            if (mst[m] != 0) begin
                wt[m]++;
                if (wt[m] == 400) chk(m == 0 ? "timeout_i" : "timeout_d", 128'(wt[m]), 128'(0));
            end
        end

        // memory slave
        if (!s_act) begin
            if (a_valid && s_aready) begin
                off    = a_addr - BASE;
                s_act  = 1'b1;
                s_we   = a_we;
                s_base = int'(off[10:3]);
                s_len  = int'(a_len);
                s_beat = 0;
            end
        end else begin
            if (s_we && a_wvalid && s_wready) begin
                mem[(s_base + s_beat) & 255] = a_wdata;
                s_beat++;
            end else if (!s_we && s_rvalid && a_rready) begin
                s_beat++;
            end
            if (s_beat > s_len) s_act = 1'b0;
        end

        // reference ownership, from stimulus only
        if (own < 0) begin
            if (m_valid[0] && m_valid[1]) own = lst ? 0 : 1;
            else if (m_valid[0])          own = 0;
            else if (m_valid[1])          own = 1;
            aph = (own >= 0);
        end else if (aph) begin
            if (m_valid[own] && s_aready) begin
                aph  = 1'b0;
                mwe  = m_we[own];
                left = int'(m_len[own]) + 1;
            end
        end else begin
            hs = mwe ? (m_wvalid[own] && s_wready) : (s_rvalid && m_rready[own]);
            if (hs) begin
                left--;
                if (left == 0) begin
                    lst = (own == 1);
                    own = -1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        clear_agents();
        @(negedge clk);
        #1;
        check_all_zero("inrst");
        @(negedge clk);
        rst_n = 1'b1;
        did_rst = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k]    = {$urandom, $urandom};
            shadow[k] = mem[k];
        end
        did_rst = 1'b0;
        ngrant  = 0;
        rst_n   = 1'b0;
        clear_agents();
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (!did_rst && cyc > 3000 && mst[0] == 2 && !m_we[0] && beat[0] == 3) do_reset();
            drive(cyc);
            #1;
            check_cycle();
            update();
        end
        chk("reset_exercised", 128'(did_rst), 128'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
